// File: rtl/div_seq_ctrl_if.sv
// Bundle between execute stage, divide sequencer and the divider IP.
// Controller side is the slave modport; the environment drives the master modport.
interface div_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic               req_valid;
    logic               req_ready;
    logic               req_signed;
    logic [WIDTH-1:0]   req_src1;
    logic [WIDTH-1:0]   req_src2;
    logic               flush;
    logic               res_valid;
    logic               res_ready;
    logic [WIDTH-1:0]   res_quot;
    logic [WIDTH-1:0]   res_rem;
    logic               busy;
    logic [WIDTH-1:0]   dvd_tdata;
    logic               dvd_tvalid;
    logic               dvd_tready;
    logic [WIDTH-1:0]   dvs_tdata;
    logic               dvs_tvalid;
    logic               dvs_tready;
    logic [2*WIDTH-1:0] dout_tdata;
    logic               dout_tvalid;

    modport slave (
        input  req_valid, req_signed, req_src1, req_src2, flush,
        input  res_ready, dvd_tready, dvs_tready,
        input  dout_tdata, dout_tvalid,
        output req_ready, res_valid, res_quot, res_rem, busy,
        output dvd_tdata, dvd_tvalid, dvs_tdata, dvs_tvalid
    );

    modport master (
        output req_valid, req_signed, req_src1, req_src2, flush,
        output res_ready, dvd_tready, dvs_tready,
        output dout_tdata, dout_tvalid,
        input  req_ready, res_valid, res_quot, res_rem, busy,
        input  dvd_tdata, dvd_tvalid, dvs_tdata, dvs_tvalid
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// DIV/DIVU sequencer: feeds operand magnitudes to an unsigned divider IP,
// sign-corrects its result and drains cancelled operations on flush.
module div_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          resetn,
    div_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             q_neg;
    logic             r_neg;
    logic             dvd_sent;
    logic             dvs_sent;
    logic             cancel;

    logic             dvd_hs;
    logic             dvs_hs;
    logic             dvd_done;
    logic             dvs_done;
    logic [WIDTH-1:0] d_quot;
    logic [WIDTH-1:0] d_rem;
    logic             s1;
    logic             s2;

    function automatic logic [WIDTH-1:0] mag(
        input logic             sgn,
        input logic [WIDTH-1:0] v
    );
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    assign s1       = bus.req_src1[WIDTH-1];
    assign s2       = bus.req_src2[WIDTH-1];
    assign d_quot   = bus.dout_tdata[2*WIDTH-1:WIDTH];
    assign d_rem    = bus.dout_tdata[WIDTH-1:0];

    assign dvd_hs   = bus.dvd_tvalid & bus.dvd_tready;
    assign dvs_hs   = bus.dvs_tvalid & bus.dvs_tready;
    assign dvd_done = dvd_sent | dvd_hs;
    assign dvs_done = dvs_sent | dvs_hs;

    assign bus.req_ready  = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.res_valid  = (state == DONE);
    assign bus.dvd_tvalid = (state == SEND) & ~dvd_sent;
    assign bus.dvs_tvalid = (state == SEND) & ~dvs_sent;
    assign bus.dvd_tdata  = dvd_mag;
    assign bus.dvs_tdata  = dvs_mag;
    assign bus.res_quot   = quot;
    assign bus.res_rem    = rem;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            dvd_mag  <= '0;
            dvs_mag  <= '0;
            quot     <= '0;
            rem      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            dvd_sent <= 1'b0;
            dvs_sent <= 1'b0;
            cancel   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid && !bus.flush) begin
                        dvd_mag <= mag(bus.req_signed, bus.req_src1);
                        dvs_mag <= mag(bus.req_signed, bus.req_src2);
                        q_neg   <= bus.req_signed & (s1 ^ s2);
                        r_neg   <= bus.req_signed & s1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (dvd_hs) dvd_sent <= 1'b1;
                    if (dvs_hs) dvs_sent <= 1'b1;
                    if (bus.flush) cancel <= 1'b1;
                    if (dvd_done && dvs_done) state <= WAIT;
                end
                WAIT: begin
                    // A flush coinciding with the result still discards it
                    if (bus.dout_tvalid) begin
                        if (cancel || bus.flush) begin
                            state    <= IDLE;
                            dvd_sent <= 1'b0;
                            dvs_sent <= 1'b0;
                            cancel   <= 1'b0;
                        end else begin
                            quot  <= q_neg ? -d_quot : d_quot;
                            rem   <= r_neg ? -d_rem : d_rem;
                            state <= DONE;
                        end
                    end else if (bus.flush) begin
                        cancel <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.flush || bus.res_ready) begin
                        state    <= IDLE;
                        dvd_sent <= 1'b0;
                        dvs_sent <= 1'b0;
                        cancel   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: behavioural divider IP plus a result scoreboard.
// Inputs change at posedge+1, outputs are sampled on the falling edge.
module tb_div_seq_ctrl;
    localparam int W      = 32;
    localparam int IP_LAT = 3;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    div_seq_ctrl_if #(.WIDTH(W)) bus ();

    div_seq_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int             n_chk = 0;
    int             n_err = 0;
    logic [2*W-1:0] sb[$];
    logic [W-1:0]   dq[$];
    logic [W-1:0]   sq[$];
    int             ip_cnt = -1;
    logic [2*W-1:0] ip_data;
    logic [W-1:0]   ip_a;
    logic [W-1:0]   ip_b;
    logic [2*W-1:0] mon_e;
    logic           in_wait;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Divider IP model: fixed latency after both operands arrive
    always @(posedge clk) begin
        #1;
        bus.dout_tvalid = 1'b0;
        if (!resetn) begin
            ip_cnt = -1;
            dq.delete();
            sq.delete();
        end else begin
            if (ip_cnt > 0) ip_cnt--;
            if (ip_cnt == 0) begin
                bus.dout_tvalid = 1'b1;
                bus.dout_tdata  = ip_data;
                ip_cnt          = -1;
            end
            if (dq.size() > 0 && sq.size() > 0) begin
                ip_a    = dq.pop_front();
                ip_b    = sq.pop_front();
                ip_data = {ip_a / ip_b, ip_a % ip_b};
                ip_cnt  = IP_LAT;
            end
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            if (bus.dvd_tvalid && bus.dvd_tready) dq.push_back(bus.dvd_tdata);
            if (bus.dvs_tvalid && bus.dvs_tready) sq.push_back(bus.dvs_tdata);
            in_wait = bus.busy && !bus.res_valid &&
                      !bus.dvd_tvalid && !bus.dvs_tvalid;
            if (bus.dout_tvalid) chk("dout_in_wait", 64'(in_wait), 64'd1);
            if (bus.res_valid && bus.res_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_res", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("res_quot", 64'(bus.res_quot), 64'(mon_e[63:32]));
                    chk("res_rem", 64'(bus.res_rem), 64'(mon_e[31:0]));
                end
            end
        end
    end

    task automatic do_req(input logic sgn, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        int n = 0;
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_signed = sgn;
        bus.req_src1   = a;
        bus.req_src2   = b;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready && n < 20);
        chk("req_accept", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_res();
        int n = 0;
        while (!bus.res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("res_timeout", 64'(bus.res_valid), 64'd1);
    endtask

    task automatic consume();
        @(posedge clk); #1 bus.res_ready = 1'b1;
        @(posedge clk); #1 bus.res_ready = 1'b0;
        @(negedge clk);
        chk("res_drop", 64'(bus.res_valid), 64'd0);
        chk("idle_ready", 64'(bus.req_ready), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.dout_tvalid && n < 50);
        chk("drain_dout", 64'(bus.dout_tvalid), 64'd1);
        chk("drain_busy", 64'(bus.busy), 64'd1);
        @(negedge clk);
        chk("drain_idle", 64'(bus.busy), 64'd0);
        chk("drain_novalid", 64'(bus.res_valid), 64'd0);
    endtask

    task automatic run_op(input logic sgn, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] e_dvd,
                          input logic [W-1:0] e_dvs, input logic [W-1:0] q,
                          input logic [W-1:0] r, input int hold);
        sb.push_back({q, r});
        do_req(sgn, a, b);
        @(negedge clk);
        chk("busy", 64'(bus.busy), 64'd1);
        chk("ready_busy", 64'(bus.req_ready), 64'd0);
        chk("dvd_tdata", 64'(bus.dvd_tdata), 64'(e_dvd));
        chk("dvs_tdata", 64'(bus.dvs_tdata), 64'(e_dvs));
        wait_res();
        chk("ready_done", 64'(bus.req_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(bus.res_valid), 64'd1);
            chk("hold_quot", 64'(bus.res_quot), 64'(q));
            chk("hold_rem", 64'(bus.res_rem), 64'(r));
        end
        consume();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_signed  = 1'b0;
        bus.req_src1    = '0;
        bus.req_src2    = '0;
        bus.flush       = 1'b0;
        bus.res_ready   = 1'b0;
        bus.dvd_tready  = 1'b1;
        bus.dvs_tready  = 1'b1;
        bus.dout_tdata  = '0;
        bus.dout_tvalid = 1'b0;
        #12;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_dvd_tv", 64'(bus.dvd_tvalid), 64'd0);
        chk("rst_dvs_tv", 64'(bus.dvs_tvalid), 64'd0);
        chk("rst_quot", 64'(bus.res_quot), 64'd0);
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(bus.req_ready), 64'd1);

        run_op(1'b0, 32'd100, 32'd7, 32'd100, 32'd7, 32'd14, 32'd2, 0);
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, 32'd7, 32'd2,
               32'hFFFFFFFD, 32'hFFFFFFFF, 0);
        run_op(1'b1, 32'd7, 32'hFFFFFFFE, 32'd7, 32'd2,
               32'hFFFFFFFD, 32'd1, 0);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd1,
               32'h80000000, 32'd0, 0);

        // divisor channel stalls after the dividend is taken
        bus.dvs_tready = 1'b0;
        sb.push_back({32'd10, 32'd0});
        do_req(1'b0, 32'd50, 32'd5);
        @(negedge clk);
        chk("both_tv", 64'({bus.dvd_tvalid, bus.dvs_tvalid}), 64'd3);
        @(negedge clk);
        chk("dvd_tv_drop", 64'(bus.dvd_tvalid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("dvs_tv_held", 64'(bus.dvs_tvalid), 64'd1);
            chk("dvs_td_held", 64'(bus.dvs_tdata), 64'd5);
        end
        @(posedge clk); #1 bus.dvs_tready = 1'b1;
        wait_res();
        consume();

        // request blocked by a simultaneous flush
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_src1  = 32'd3;
        bus.req_src2  = 32'd1;
        bus.flush     = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        @(negedge clk);
        chk("flush_block", 64'(bus.busy), 64'd0);

        // flush in SEND, then flush in WAIT
        bus.res_ready  = 1'b1;
        bus.dvd_tready = 1'b0;
        bus.dvs_tready = 1'b0;
        do_req(1'b0, 32'd77, 32'd7);
        @(posedge clk); #1 bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_tv_held", 64'(bus.dvd_tvalid), 64'd1);
        @(posedge clk); #1;
        bus.dvd_tready = 1'b1;
        bus.dvs_tready = 1'b1;
        drain();
        do_req(1'b1, 32'hFFFFFF9C, 32'd3);
        @(posedge clk); #1 bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        drain();
        bus.res_ready = 1'b0;
        run_op(1'b0, 32'd9, 32'd4, 32'd9, 32'd4, 32'd2, 32'd1, 0);

        // flush in DONE drops the result
        do_req(1'b0, 32'd8, 32'd2);
        wait_res();
        @(posedge clk); #1 bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        @(negedge clk);
        chk("done_flush_valid", 64'(bus.res_valid), 64'd0);
        chk("done_flush_busy", 64'(bus.busy), 64'd0);

        run_op(1'b0, 32'd1000, 32'd10, 32'd1000, 32'd10, 32'd100, 32'd0, 5);

        // asynchronous reset while waiting on the IP
        do_req(1'b0, 32'd20, 32'd3);
        @(posedge clk); #1 resetn = 1'b0;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_ready", 64'(bus.req_ready), 64'd1);
        chk("arst_quot", 64'(bus.res_quot), 64'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("arst_idle", 64'(bus.busy), 64'd0);
        run_op(1'b0, 32'd9, 32'd4, 32'd9, 32'd4, 32'd2, 32'd1, 0);

        repeat (10) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
